doraemon_select: RTL and testbench
==================================

# doraemon_select

Weighted-preference selection core in the clk2 domain of the Doraemon pipeline. It consumes records popped from the clk1→clk2 async FIFO and keeps five "doors", each holding one stored Doraemon. For every incoming record after the first five, it scores all doors using that record's weights, picks the best door, and emits `{door, id}` toward the output FIFO. The winning door is then overwritten with the incoming record.

## Interface
- `DOORS`, 5, number of stored slots (fixed; index width 3)
- `SCORE_W`, 13, weighted-score width
- `clk2` input 1, sole clock, rising edge
- `rst_n` input 1, asynchronous active-low reset
- `in_valid` input 1, record available from upstream FIFO
- `in_ready` output 1, block can accept a record this cycle
- `doraemon_id` input 5, record id
- `size` input 8, size attribute
- `iq_score` input 8, IQ attribute
- `eq_score` input 8, EQ attribute
- `size_weight` input 3, weight applied to stored sizes
- `iq_weight` input 3, weight applied to stored IQ
- `eq_weight` input 3, weight applied to stored EQ
- `out_valid` output 1, result valid
- `out_ready` input 1, downstream FIFO not full
- `out` output 8, `{door[2:0], id[4:0]}` of the selected stored record

## Operation
- Clock and reset: one clock, `clk2`. Reset `rst_n` is asynchronous and active-low.
- States: IDLE, CALC, OUT.
- IDLE:
  - `in_ready`=1.
  - Handshake is `in_valid && in_ready`. On handshake, the record and its three weights are latched into the incoming register.
- Fill phase:
  - While `fill_cnt` < 5, the accepted record is written to `door[fill_cnt]` and `fill_cnt` increments.
  - The state remains IDLE and no output is produced.
- Select phase (`fill_cnt` == 5): an accepted record moves the state to CALC.
- Score of door d: `size_weight*size_d + iq_weight*iq_d + eq_weight*eq_d`.
  - The weights are the incoming record's; the attributes are door d's.
  - Unsigned. Each product is 11 bits; the sum is 13 bits (max 5355). No overflow is possible.
- CALC (sequential):
  - `idx` steps 0→4, one door per cycle.
  - At idx 0, `best` is loaded unconditionally.
  - After that, `best` is replaced only on a strictly greater score, so ties go to the lowest door index.
  - After idx 4, the state moves to OUT.
- OUT:
  - `out_valid`=1 and `out`={best_door, door[best_door].id}, held stable until `out_ready`.
  - On `out_valid && out_ready`: `door[best_door]` ← incoming record, state → IDLE.
- `in_ready`=0 in CALC and OUT; at most one record is in flight.
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out`=0.
  - `fill_cnt`=0, `idx`=0, all doors cleared, state IDLE.
- Reset mid-CALC/OUT: the in-flight record is discarded and the block returns to the fill phase; the next 5 records refill the doors.
- `out` is 0 whenever `out_valid`=0.

## Timing
- Acceptance edge = E0. Sequential mode: CALC covers edges E1..E5, and `out_valid` is registered high after E5 (5-cycle latency).
- `in_ready` falls after E0 and rises the cycle after the output handshake edge.
- Back-to-back throughput is one result per 7 cycles when `out_ready` is held at 1.
- Fill records are accepted every cycle (`in_ready` stays 1).
- `out_valid` and `out` do not change while `out_ready`=0.

## Configuration
- `DORAEMON_PARALLEL_EN` defined:
  - All five scores are computed in the same cycle, with a combinational max tree (lowest index wins ties).
  - CALC lasts one cycle; `out_valid` is high after E1.
- Undefined: the sequential single-scorer datapath described above.
- Both modes produce identical `out` sequences.

## Structure
- Shared package `doraemon_pkg`:
  - record struct `{id, size, iq, eq}`
  - weight struct
  - `DOORS`, `SCORE_W`, `DOOR_W`=3
  - state enum
- Sub-module `doraemon_score`: purely combinational weighted sum. Instantiated once in sequential mode, five times when `DORAEMON_PARALLEL_EN` is defined.

## Test plan
- Fill and first select:
  - Fill doors with ids 1..5 and sizes 10,20,30,40,50 (iq=eq=0).
  - Send id 9 with weights (1,0,0).
  - Expect `out`=8'b100_00101 (door 4, id 5), 5 cycles after acceptance; door 4 then holds id 9.
- Tie: all doors identical, weights (7,7,7) → `out`=door 0, id of door 0.
- Zero weights: any doors, weights (0,0,0) → all scores 0 → door 0 selected.
- Maximum values:
  - Door 3 holds attributes 255/255/255, others 254, weights (7,7,7).
  - Door 3 wins (score 5355); check for no wrap.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles in OUT.
  - `out` must stay stable and `in_ready` must stay 0; the handshake on release updates the door.
- Reset mid-CALC:
  - Assert `rst_n`=0 during CALC.
  - Outputs go to reset values immediately; the next 5 records produce no output, and the 6th produces a result computed from the new doors only.

Source files
------------

// File: rtl/doraemon_pkg.sv
// Shared definitions for the doraemon_select slice (clk2 domain).
//   record_t : one stored/incoming Doraemon {id, size, iq, eq}
//   weight_t : per-record attribute weights applied to the stored doors
//   state_t  : selection controller states
// Optional build macro used by the slice: DORAEMON_PARALLEL_EN.
package doraemon_pkg;

  localparam int unsigned DOORS   = 5;
  localparam int unsigned SCORE_W = 13;
  localparam int unsigned DOOR_W  = 3;
  localparam int unsigned ID_W    = 5;
  localparam int unsigned ATTR_W  = 8;
  localparam int unsigned WGT_W   = 3;
  localparam int unsigned PROD_W  = ATTR_W + WGT_W;

  localparam logic [DOOR_W-1:0] DOORS_CNT = DOOR_W'(DOORS);
  localparam logic [DOOR_W-1:0] LAST_DOOR = DOOR_W'(DOORS - 1);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ATTR_W-1:0] size;
    logic [ATTR_W-1:0] iq;
    logic [ATTR_W-1:0] eq;
  } record_t;

  typedef struct packed {
    logic [WGT_W-1:0] size_w;
    logic [WGT_W-1:0] iq_w;
    logic [WGT_W-1:0] eq_w;
  } weight_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_OUT
  } state_t;

endpackage

// File: rtl/doraemon_score.sv
// Purely combinational weighted score of one stored door.
//   rec   : stored door record (attributes used, id ignored)
//   w     : weights of the incoming record
//   score : size_w*size + iq_w*iq + eq_w*eq, unsigned, cannot overflow
module doraemon_score
  import doraemon_pkg::*;
(
  input  record_t              rec,
  input  weight_t              w,
  output logic [SCORE_W-1:0]   score
);

  logic [PROD_W-1:0] p_size;
  logic [PROD_W-1:0] p_iq;
  logic [PROD_W-1:0] p_eq;
  logic [ID_W-1:0]   unused_id;

  always_comb begin
    p_size    = PROD_W'(w.size_w) * PROD_W'(rec.size);
    p_iq      = PROD_W'(w.iq_w)   * PROD_W'(rec.iq);
    p_eq      = PROD_W'(w.eq_w)   * PROD_W'(rec.eq);
    score     = SCORE_W'(p_size) + SCORE_W'(p_iq) + SCORE_W'(p_eq);
    unused_id = rec.id;
  end

endmodule

// File: rtl/doraemon_select.sv
// Weighted-preference selection core (clk2 domain).
// Keeps five doors; the first five records after reset fill them. Each later
// record scores every door with its own weights, emits {door, id} of the best
// door (ties -> lowest index), then replaces that door with itself.
// Ports:
//   clk2, rst_n (async, active-low)
//   in_valid/in_ready, doraemon_id, size, iq_score, eq_score,
//   size_weight, iq_weight, eq_weight : upstream record + weights
//   out_valid/out_ready, out[7:0] = {door[2:0], id[4:0]} : result
// Build macro DORAEMON_PARALLEL_EN: score all doors in one CALC cycle
// (five scorers + compare chain) instead of one door per cycle.
module doraemon_select
  import doraemon_pkg::*;
(
  input  logic        clk2,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  doraemon_id,
  input  logic [7:0]  size,
  input  logic [7:0]  iq_score,
  input  logic [7:0]  eq_score,
  input  logic [2:0]  size_weight,
  input  logic [2:0]  iq_weight,
  input  logic [2:0]  eq_weight,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out
);

  state_t            state_q, state_d;
  logic [DOOR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [DOOR_W-1:0] best_q, best_d;
  record_t           door_q [DOORS];
  record_t           door_d [DOORS];
  record_t           inc_rec_q, inc_rec_d;
  weight_t           inc_w_q, inc_w_d;
  record_t           in_rec;
  weight_t           in_w;

  always_comb begin
    in_rec = '{id: doraemon_id, size: size, iq: iq_score, eq: eq_score};
    in_w   = '{size_w: size_weight, iq_w: iq_weight, eq_w: eq_weight};
  end

`ifdef DORAEMON_PARALLEL_EN
  logic [SCORE_W-1:0] score_par [DOORS];
  logic [SCORE_W-1:0] best_par_score;
  logic [DOOR_W-1:0]  best_par;

  for (genvar g = 0; g < DOORS; g++) begin : g_score
    doraemon_score u_score (
      .rec   (door_q[g]),
      .w     (inc_w_q),
      .score (score_par[g])
    );
  end

  // Ascending scan with strict '>' keeps the lowest index on ties.
  always_comb begin
    best_par       = '0;
    best_par_score = score_par[0];
    for (int unsigned i = 1; i < DOORS; i++) begin
      if (score_par[i] > best_par_score) begin
        best_par_score = score_par[i];
        best_par       = DOOR_W'(i);
      end
    end
  end
`else
  logic [DOOR_W-1:0]  idx_q, idx_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic [SCORE_W-1:0] score_seq;

  doraemon_score u_score (
    .rec   (door_q[idx_q]),
    .w     (inc_w_q),
    .score (score_seq)
  );
`endif

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    best_d     = best_q;
    door_d     = door_q;
    inc_rec_d  = inc_rec_q;
    inc_w_d    = inc_w_q;
`ifndef DORAEMON_PARALLEL_EN
    idx_d        = idx_q;
    best_score_d = best_score_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          inc_rec_d = in_rec;
          inc_w_d   = in_w;
          if (fill_cnt_q < DOORS_CNT) begin
            door_d[fill_cnt_q] = in_rec;
            fill_cnt_d         = fill_cnt_q + 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
`ifdef DORAEMON_PARALLEL_EN
        best_d  = best_par;
        state_d = ST_OUT;
`else
        // Door 0 seeds best unconditionally; later doors need a strictly
        // greater score, so ties stay with the lower index.
        if ((idx_q == '0) || (score_seq > best_score_q)) begin
          best_d       = idx_q;
          best_score_d = score_seq;
        end
        if (idx_q == LAST_DOOR) begin
          idx_d   = '0;
          state_d = ST_OUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
`endif
      end
      ST_OUT: begin
        if (out_ready) begin
          door_d[best_q] = inc_rec_q;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fill_cnt_q <= '0;
      best_q     <= '0;
      inc_rec_q  <= '0;
      inc_w_q    <= '0;
      for (int unsigned i = 0; i < DOORS; i++) begin
        door_q[i] <= '0;
      end
`ifndef DORAEMON_PARALLEL_EN
      idx_q        <= '0;
      best_score_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      best_q     <= best_d;
      inc_rec_q  <= inc_rec_d;
      inc_w_q    <= inc_w_d;
      for (int unsigned i = 0; i < DOORS; i++) begin
        door_q[i] <= door_d[i];
      end
`ifndef DORAEMON_PARALLEL_EN
      idx_q        <= idx_d;
      best_score_q <= best_score_d;
`endif
    end
  end

  // Doors do not change outside a handshake, so the result is stable in OUT.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_OUT);
    out       = out_valid ? {best_q, door_q[best_q].id} : '0;
  end

endmodule

// File: tb/tb_doraemon_select.sv
module tb_doraemon_select;

`ifdef DORAEMON_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 5;
`endif

  logic       clk2;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] doraemon_id;
  logic [7:0] size;
  logic [7:0] iq_score;
  logic [7:0] eq_score;
  logic [2:0] size_weight;
  logic [2:0] iq_weight;
  logic [2:0] eq_weight;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;

  doraemon_select dut (
    .clk2        (clk2),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .doraemon_id (doraemon_id),
    .size        (size),
    .iq_score    (iq_score),
    .eq_score    (eq_score),
    .size_weight (size_weight),
    .iq_weight   (iq_weight),
    .eq_weight   (eq_weight),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  int n_checks = 0;
  int n_errors = 0;
  int last_out = 0;

  // Reference model: plain arrays of stored attributes.
  int m_id [5];
  int m_sz [5];
  int m_iq [5];
  int m_eq [5];
  int m_fill;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int model_best(input int sw, input int iw, input int ew);
    int bs;
    int bd;
    bs = -1;
    bd = 0;
    for (int d = 0; d < 5; d++) begin
      int s;
      s = sw * m_sz[d] + iw * m_iq[d] + ew * m_eq[d];
      if (s > bs) begin
        bs = s;
        bd = d;
      end
    end
    return bd;
  endfunction

  task automatic model_clear();
    m_fill = 0;
    for (int d = 0; d < 5; d++) begin
      m_id[d] = 0; m_sz[d] = 0; m_iq[d] = 0; m_eq[d] = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out"}, int'(out), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(posedge clk2); #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic drive(input int id, input int sz, input int iq, input int eq,
                       input int sw, input int iw, input int ew);
    doraemon_id = 5'(id);
    size        = 8'(sz);
    iq_score    = 8'(iq);
    eq_score    = 8'(eq);
    size_weight = 3'(sw);
    iq_weight   = 3'(iw);
    eq_weight   = 3'(ew);
    in_valid    = 1'b1;
  endtask

  // Sends one record; a select record is followed through CALC, `hold`
  // cycles of backpressure and the output handshake.
  task automatic send(input int id, input int sz, input int iq, input int eq,
                      input int sw, input int iw, input int ew, input int hold);
    int n;
    int bd;
    int exp_out;
    check("pre_in_ready", int'(in_ready), 1);
    drive(id, sz, iq, eq, sw, iw, ew);
    @(posedge clk2); #1;
    in_valid = 1'b0;
    if (m_fill < 5) begin
      m_id[m_fill] = id; m_sz[m_fill] = sz; m_iq[m_fill] = iq; m_eq[m_fill] = eq;
      m_fill++;
      check("fill_out_valid", int'(out_valid), 0);
      check("fill_in_ready", int'(in_ready), 1);
    end else begin
      bd      = model_best(sw, iw, ew);
      exp_out = bd * 32 + m_id[bd];
      check("busy_in_ready", int'(in_ready), 0);
      n = 0;
      do begin
        @(posedge clk2); #1;
        n++;
      end while (!out_valid && n < 20);
      check("latency", n, LAT);
      check("sel_out", int'(out), exp_out);
      last_out = int'(out);
      for (int c = 0; c < hold; c++) begin
        @(posedge clk2); #1;
        check("bp_out", int'(out), exp_out);
        check("bp_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk2); #1;
      out_ready = 1'b0;
      check("post_out_valid", int'(out_valid), 0);
      check("post_out", int'(out), 0);
      check("post_in_ready", int'(in_ready), 1);
      m_id[bd] = id; m_sz[bd] = sz; m_iq[bd] = iq; m_eq[bd] = eq;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    model_clear();
    @(posedge clk2); #1;
    do_reset();

    // Fill ids 1..5 with sizes 10..50, then select on size only.
    for (int i = 0; i < 5; i++) send(i + 1, 10 * (i + 1), 0, 0, 0, 0, 0, 0);
    send(9, 60, 0, 0, 1, 0, 0, 0);
    check("first_sel_const", last_out, 8'b100_00101);
    // Door 4 now holds id 9 (size 60), so it wins again.
    send(11, 1, 0, 0, 1, 0, 0, 0);
    check("replaced_door4", last_out, {3'd4, 5'd9});

    // Tie: identical doors, full weights -> door 0.
    do_reset();
    for (int i = 0; i < 5; i++) send(i + 3, 100, 100, 100, 0, 0, 0, 0);
    send(20, 1, 2, 3, 7, 7, 7, 0);
    check("tie_door0", last_out, {3'd0, 5'd3});

    // Zero weights -> door 0 regardless of contents.
    do_reset();
    for (int i = 0; i < 5; i++) send(i + 12, 50 * i, 40 * i, 30 * i, 0, 0, 0, 0);
    send(21, 0, 0, 0, 0, 0, 0, 0);
    check("zero_w_door0", last_out, {3'd0, 5'd12});

    // Maximum attributes on door 3 with backpressure in OUT.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 3) send(30, 255, 255, 255, 0, 0, 0, 0);
      else        send(i + 24, 254, 254, 254, 0, 0, 0, 0);
    end
    send(31, 0, 0, 0, 7, 7, 7, 10);
    check("max_door3", last_out, {3'd3, 5'd30});
    // Door 3 now holds id 31 (all zeros): door 0 (254s) wins on ties.
    send(2, 5, 5, 5, 7, 7, 7, 0);
    check("after_bp_update", last_out, {3'd0, 5'd24});

    // Reset in the middle of CALC.
    check("midcalc_in_ready", int'(in_ready), 1);
    drive(17, 9, 9, 9, 3, 3, 3);
    @(posedge clk2); #1;
    in_valid = 1'b0;
    @(posedge clk2); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midcalc_rst");
    @(posedge clk2); #1;
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 5; i++) send(i + 1, 5 * i, 7 * (4 - i), 1, 0, 0, 0, 0);
    send(8, 0, 0, 0, 0, 1, 0, 0);
    check("after_midcalc_rst", last_out, {3'd0, 5'd1});

    // Randomized traffic against the model.
    do_reset();
    for (int t = 0; t < 45; t++) begin
      int r;
      r = int'($urandom_range(0, 3));
      send(int'($urandom_range(0, 31)),
           (r == 0) ? 255 : int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)),
           (r == 1) ? 128 : int'($urandom_range(0, 255)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
